instr_fetch_ctrl: RTL and testbench
===================================

# instr_fetch_ctrl

Sequencer for the instruction fetch path. It owns the program counter, drives the address of the combinational `Instr_Mem` ROM and captures each returned word into a one-entry output register. It hands that register to decode over a valid/ready handshake. It also handles start/stop control, branch/jump redirects and PC wrap-around, and keeps a saturating count of delivered instructions.

## Interface
Parameters:
- `ADDR_W`, 8: PC and `imem_addr` width
- `DATA_W`, 32: instruction width
- `RESET_PC`, 0: PC value after reset
- `CNT_W`, 16: width of `fetch_count`

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `start`  in  1  level; leave IDLE and begin fetching from the current PC
- `stop`  in  1  level; finish the held instruction, then return to IDLE
- `redirect`  in  1  one-cycle pulse; load `redirect_pc` and flush the held instruction
- `redirect_pc`  in  ADDR_W  target PC for `redirect`
- `imem_addr`  out  ADDR_W  ROM address; equals the PC register (combinational from the register)
- `imem_rd`  in  DATA_W  ROM read data; combinational, same cycle as `imem_addr`
- `instr`  out  DATA_W  held instruction
- `instr_pc`  out  ADDR_W  address `instr` was fetched from
- `instr_valid`  out  1  `instr` and `instr_pc` are valid
- `instr_ready`  in  1  decode accepts the held instruction this cycle
- `busy`  out  1  state != IDLE
- `fetch_count`  out  CNT_W  number of handshakes completed (`instr_valid & instr_ready`); saturates at all-ones

## Operation
- States:
  - IDLE: no fetch; PC held.
  - RUN: fetch every cycle the output register is free.
  - DRAIN: no new fetch; wait for the held instruction to leave.
- Output register is "free" when `!instr_valid | instr_ready`.
- RUN with the register free and no redirect:
  - `instr <= imem_rd`, `instr_pc <= pc`, `instr_valid <= 1`, `pc <= pc + 1`.
- RUN with the register not free: PC and the register hold; `imem_addr` stays stable.
- PC arithmetic is modulo 2^ADDR_W: `pc = 2^ADDR_W-1` fetches, then wraps to 0. There is no error flag.
- `redirect` in RUN or DRAIN:
  - `pc <= redirect_pc` and `instr_valid <= 0`, whatever the value of `instr_ready`.
  - The flushed instruction does not count, even if `instr_ready` was high.
  - Redirect has priority over fetch.
- `redirect` in IDLE: `pc <= redirect_pc` only. Valid is already 0. Used to set the start address.
- Transitions:
  - IDLE → RUN: on `start`. `stop` is ignored in IDLE.
  - RUN → DRAIN: on `stop` when `instr_valid & !instr_ready`.
  - RUN → IDLE: on `stop` when the register is free or a redirect is present. No fetch occurs that cycle; valid clears.
  - DRAIN → IDLE: on `instr_ready`, or on `redirect`. Valid clears.
  - `start` in RUN or DRAIN: ignored.
- `stop` outranks fetch in RUN: the cycle `stop` is sampled, nothing new is captured.
- `fetch_count` increments on every cycle where `instr_valid & instr_ready` and no `redirect`. It holds at 2^CNT_W-1.

## Timing
- Reset values:
  - state IDLE
  - `pc = RESET_PC`, `imem_addr = RESET_PC`
  - `instr = 0`, `instr_pc = 0`, `instr_valid = 0`
  - `busy = 0`, `fetch_count = 0`
- `start` sampled at edge k: RUN after edge k, first `instr_valid` after edge k+1.
- Throughput: 1 instruction/cycle while `instr_ready` stays high.
- Fetch latency: 1 cycle from PC to `instr`.
- Redirect: sampled at edge k; valid low after edge k; the target instruction is valid after edge k+1 (1 bubble).
- `instr`, `instr_pc` and `instr_valid` stay stable while `instr_valid & !instr_ready`.
- Reset during RUN or DRAIN aborts immediately: the held instruction is discarded and the counter is cleared.

## Structure
- Shared package `fetch_pkg`:
  - state enum `fetch_state_t` (IDLE, RUN, DRAIN)
  - `RESET_PC` default
  - width constants
- No sub-module is required. The output register with handshake can optionally be split out as `pipe_reg` if the decode stage reuses it.
- `Instr_Mem` is instantiated by the parent, not inside this block.

## Test plan
- Reset, then `start` with `instr_ready=1`:
  - valid words `0x200100CA` at pc 0 and `0x00210820` at pc 1, on consecutive cycles.
  - `fetch_count` increments by 1 per cycle.
- Back-pressure: hold `instr_ready=0` for 3 cycles after the first valid.
  - `instr=0x200100CA`, `instr_pc=0` and `imem_addr=1` stay stable.
  - The count does not change.
  - Releasing `instr_ready` resumes with pc 1 with no loss or duplication.
- Redirect to pc 5 while `instr_valid=1`:
  - valid drops for exactly 1 cycle.
  - next `instr_pc=5`, `instr=0x002228A7`.
  - the flushed word is not counted.
- `stop` with `instr_valid=1`, `instr_ready=0`:
  - DRAIN, `busy=1`.
  - asserting `instr_ready` for one cycle → IDLE, `busy=0`, valid 0, PC holds next address.
- Redirect to 254 in IDLE, then `start` with `instr_ready=1`:
  - `instr_pc` sequence 254, 255, 0, 1.
  - words 255/254 read as 0.
- Async reset asserted mid-RUN between edges:
  - `instr_valid`, `busy` and `fetch_count` go to 0 before the next edge.
  - `imem_addr` goes to `RESET_PC` before the next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;

   // Sequencer states: IDLE (parked), RUN (fetching), DRAIN (waiting for the held word to leave)
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   localparam int unsigned ADDR_W_DEF   = 8;
   localparam int unsigned DATA_W_DEF   = 32;
   localparam int unsigned CNT_W_DEF    = 16;
   localparam int unsigned RESET_PC_DEF = 0;

endpackage : fetch_pkg

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, addresses the combinational
// instruction ROM, captures each word into a one-entry output register and
// hands it to decode over valid/ready. Supports start/stop, redirects and a
// saturating count of delivered instructions.
module instr_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned RESET_PC = RESET_PC_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rd,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  fetch_count
);

   localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
   logic              valid_q, valid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              reg_free;
   logic              handshake;

   // The output register can take a new word when empty or being consumed now
   assign reg_free  = !valid_q || instr_ready;
   assign handshake = valid_q && instr_ready;

   // Next-state, PC and output-register control; redirect outranks fetch, stop outranks fetch
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;

      case (state_q)
         IDLE: begin
            // Redirect while parked just presets the start address
            if (redirect) begin
               pc_d = redirect_pc;
            end
            if (start) begin
               state_d = RUN;
            end
         end

         RUN: begin
            if (stop) begin
               // No capture on the stop cycle; park at once unless a word must drain
               if (reg_free || redirect) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
               end else begin
                  state_d = DRAIN;
               end
               if (redirect) begin
                  pc_d = redirect_pc;
               end
            end else if (redirect) begin
               // Flush the held word regardless of ready; target fetch happens next cycle
               pc_d    = redirect_pc;
               valid_d = 1'b0;
            end else if (reg_free) begin
               instr_d    = imem_rd;
               instr_pc_d = pc_q;
               valid_d    = 1'b1;
               pc_d       = pc_q + ADDR_W'(1);
            end
         end

         DRAIN: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               valid_d = 1'b0;
               state_d = IDLE;
            end else if (instr_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // Delivered-instruction counter: flushed words never count, holds at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (handshake && !redirect && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State, PC, output register and counter; asynchronous reset discards everything
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= PC_INIT;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         cnt_q      <= cnt_d;
      end
   end

   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = valid_q;
   assign busy        = (state_q != IDLE);
   assign fetch_count = cnt_q;

endmodule : instr_fetch_ctrl

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a small ROM and a handshake scoreboard.
module tb_instr_fetch_ctrl;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 3;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] word;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              stop;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rd;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              busy;
   logic [CNT_W-1:0]  fetch_count;

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] rom(input logic [ADDR_W-1:0] a);
      case (a)
         8'd0:    return 32'h200100CA;
         8'd1:    return 32'h00210820;
         8'd2:    return 32'h8C430004;
         8'd3:    return 32'hAC430008;
         8'd4:    return 32'h10400003;
         8'd5:    return 32'h002228A7;
         8'd6:    return 32'h08000000;
         default: return 32'h00000000;
      endcase
   endfunction

   assign imem_rd = rom(imem_addr);

   instr_fetch_ctrl #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .RESET_PC(0),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem_addr  (imem_addr),
      .imem_rd    (imem_rd),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .busy       (busy),
      .fetch_count(fetch_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [ADDR_W-1:0] pc);
      exp_t e;
      e.pc   = pc;
      e.word = rom(pc);
      sb.push_back(e);
   endtask

   // Score any handshake about to happen at the coming edge, then advance one cycle
   task automatic tick();
      exp_t e;
      if (instr_valid && instr_ready && !redirect) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 64'(sb.size()), 64'd1);
         end else begin
            e = sb.pop_front();
            chk("hs_pc", 64'(instr_pc), 64'(e.pc));
            chk("hs_instr", 64'(instr), 64'(e.word));
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      stop        = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      instr_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      chk("rst_valid", 64'(instr_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_count", 64'(fetch_count), 64'd0);
      chk("rst_addr", 64'(imem_addr), 64'd0);
      chk("rst_instr", 64'(instr), 64'd0);
      chk("rst_instr_pc", 64'(instr_pc), 64'd0);

      // Streaming with ready high: one word per cycle
      push(8'd0); push(8'd1); push(8'd2);
      start = 1'b1; instr_ready = 1'b1;
      tick();
      start = 1'b0;
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_first_valid", 64'(instr_valid), 64'd0);
      tick();
      chk("run_valid", 64'(instr_valid), 64'd1);
      chk("run_pc0", 64'(instr_pc), 64'd0);
      chk("run_cnt0", 64'(fetch_count), 64'd0);
      chk("run_addr1", 64'(imem_addr), 64'd1);
      tick();
      chk("run_pc1", 64'(instr_pc), 64'd1);
      chk("run_cnt1", 64'(fetch_count), 64'd1);
      tick();
      chk("run_cnt2", 64'(fetch_count), 64'd2);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_busy", 64'(busy), 64'd0);
      chk("stop_valid", 64'(instr_valid), 64'd0);
      chk("stop_cnt", 64'(fetch_count), 64'd3);
      chk("stop_addr", 64'(imem_addr), 64'd3);

      // Back-pressure: redirect to 0 in IDLE, then hold ready low
      redirect = 1'b1; redirect_pc = 8'd0; instr_ready = 1'b0;
      tick();
      redirect = 1'b0;
      chk("idle_redir_addr", 64'(imem_addr), 64'd0);
      chk("idle_redir_busy", 64'(busy), 64'd0);
      push(8'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("bp_instr", 64'(instr), 64'h200100CA);
         chk("bp_pc", 64'(instr_pc), 64'd0);
         chk("bp_addr", 64'(imem_addr), 64'd1);
         chk("bp_cnt", 64'(fetch_count), 64'd3);
         tick();
      end
      instr_ready = 1'b1;
      tick();
      chk("bp_resume_pc", 64'(instr_pc), 64'd1);
      chk("bp_resume_cnt", 64'(fetch_count), 64'd4);

      // Redirect to 5 while a word is held and ready is high: flushed, not counted
      redirect = 1'b1; redirect_pc = 8'd5;
      tick();
      redirect = 1'b0;
      chk("rd_bubble", 64'(instr_valid), 64'd0);
      chk("rd_cnt", 64'(fetch_count), 64'd4);
      chk("rd_addr", 64'(imem_addr), 64'd5);
      push(8'd5);
      instr_ready = 1'b0;
      tick();
      chk("rd_valid", 64'(instr_valid), 64'd1);
      chk("rd_pc", 64'(instr_pc), 64'd5);
      chk("rd_instr", 64'(instr), 64'h002228A7);

      // Stop with the word stalled: DRAIN until decode takes it
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("drain_busy", 64'(busy), 64'd1);
      chk("drain_valid", 64'(instr_valid), 64'd1);
      tick();
      chk("drain_hold_busy", 64'(busy), 64'd1);
      chk("drain_hold_pc", 64'(instr_pc), 64'd5);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("drain_exit_busy", 64'(busy), 64'd0);
      chk("drain_exit_valid", 64'(instr_valid), 64'd0);
      chk("drain_exit_addr", 64'(imem_addr), 64'd6);
      chk("drain_exit_cnt", 64'(fetch_count), 64'd5);

      // PC wrap from 254 through 0, counter saturating at 7
      redirect = 1'b1; redirect_pc = 8'd254;
      tick();
      redirect = 1'b0;
      push(8'd254); push(8'd255); push(8'd0); push(8'd1);
      start = 1'b1; instr_ready = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("wrap_pc254", 64'(instr_pc), 64'd254);
      chk("wrap_instr254", 64'(instr), 64'd0);
      tick();
      chk("wrap_pc255", 64'(instr_pc), 64'd255);
      chk("wrap_cnt6", 64'(fetch_count), 64'd6);
      tick();
      chk("wrap_pc0", 64'(instr_pc), 64'd0);
      chk("wrap_cnt7", 64'(fetch_count), 64'd7);
      tick();
      chk("wrap_pc1", 64'(instr_pc), 64'd1);
      chk("wrap_addr2", 64'(imem_addr), 64'd2);
      chk("sat_cnt", 64'(fetch_count), 64'd7);
      chk("sb_left", 64'(sb.size()), 64'd1);

      // Asynchronous reset between edges while running
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", 64'(instr_valid), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_cnt", 64'(fetch_count), 64'd0);
      chk("arst_addr", 64'(imem_addr), 64'd0);
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      instr_ready = 1'b0;
      tick();
      chk("post_rst_busy", 64'(busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_instr_fetch_ctrl
